// File: rtl/sap_controller.sv
// rtl/sap_controller.sv - SAP-1 control sequencer: T1-T6 ring counter and control-word decode
//
// Purpose: steps each instruction through a six-state ring (T1-T6) on the
// falling clock edge and decodes the 12-bit control word for the SAP datapath.
// Datapath registers sample on the rising edge, so each control word gets a
// half-cycle of setup.
//
// Ports:
//   clk          system clock; state changes on the falling edge
//   async_reset  asynchronous, active-high reset to RESET
//   run          1: ring counter advances; 0: state and control word hold
//   opcode[3:0]  upper nibble of IR; must be stable T4 through T6
//   con[11:0]    {Cp, Ep, Lm_n, CE_n, Li_n, Ei_n, La_n, Ea, Su, Eu, Lb_n, Lo_n}
//   t_state[5:0] one-hot ring state, bit 0 = T1; 0 in RESET and HALT
//   hlt          high while halted
module sap_controller (
  input  logic        clk,
  input  logic        async_reset,
  input  logic        run,
  input  logic [3:0]  opcode,
  output logic [11:0] con,
  output logic [5:0]  t_state,
  output logic        hlt
);

  typedef enum logic [2:0] {
    RESET = 3'd0,
    T1    = 3'd1,
    T2    = 3'd2,
    T3    = 3'd3,
    T4    = 3'd4,
    T5    = 3'd5,
    T6    = 3'd6,
    HALT  = 3'd7
  } state_t;

  localparam logic [3:0] OP_LDA = 4'b0000;
  localparam logic [3:0] OP_ADD = 4'b0001;
  localparam logic [3:0] OP_SUB = 4'b0010;
  localparam logic [3:0] OP_OUT = 4'b1110;
  localparam logic [3:0] OP_HLT = 4'b1111;

  // All strobes inactive: the active-low loads/enables held high.
  localparam logic [11:0] CON_IDLE    = 12'h3E3;
  localparam logic [11:0] CON_FETCH1  = 12'h5E3;  // Ep, Lm_n
  localparam logic [11:0] CON_FETCH2  = 12'hBE3;  // Cp
  localparam logic [11:0] CON_FETCH3  = 12'h263;  // CE_n, Li_n
  localparam logic [11:0] CON_IR_MAR  = 12'h1A3;  // Lm_n, Ei_n
  localparam logic [11:0] CON_RAM_A   = 12'h2C3;  // CE_n, La_n
  localparam logic [11:0] CON_RAM_B   = 12'h2E1;  // CE_n, Lb_n
  localparam logic [11:0] CON_ALU_A   = 12'h3C7;  // La_n, Eu
  localparam logic [11:0] CON_ALU_SUB = 12'h3CF;  // La_n, Eu, Su
  localparam logic [11:0] CON_A_OUT   = 12'h3F2;  // Ea, Lo_n

  state_t state;
  state_t next_state;

  // Asynchronous reset wins over any edge, so a release that coincides with a
  // falling edge leaves the state in RESET until the following falling edge.
  always_ff @(negedge clk or posedge async_reset) begin
    if (async_reset) begin
      state <= RESET;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    if (run) begin
      case (state)
        RESET:   next_state = T1;
        T1:      next_state = T2;
        T2:      next_state = T3;
        T3:      next_state = T4;
        T4:      next_state = (opcode == OP_HLT) ? HALT : T5;
        T5:      next_state = T6;
        T6:      next_state = T1;
        HALT:    next_state = HALT;
        default: next_state = RESET;
      endcase
    end
  end

  // Control word is a pure function of state and opcode; holding the state
  // while run is low therefore holds the word as well.
  always_comb begin
    con     = CON_IDLE;
    t_state = 6'b000000;
    hlt     = 1'b0;
    case (state)
      T1: begin
        t_state = 6'b000001;
        con     = CON_FETCH1;
      end
      T2: begin
        t_state = 6'b000010;
        con     = CON_FETCH2;
      end
      T3: begin
        t_state = 6'b000100;
        con     = CON_FETCH3;
      end
      T4: begin
        t_state = 6'b001000;
        case (opcode)
          OP_LDA, OP_ADD, OP_SUB: con = CON_IR_MAR;
          OP_OUT:                 con = CON_A_OUT;
          default:                con = CON_IDLE;
        endcase
      end
      T5: begin
        t_state = 6'b010000;
        case (opcode)
          OP_LDA:         con = CON_RAM_A;
          OP_ADD, OP_SUB: con = CON_RAM_B;
          default:        con = CON_IDLE;
        endcase
      end
      T6: begin
        t_state = 6'b100000;
        case (opcode)
          OP_ADD:  con = CON_ALU_A;
          OP_SUB:  con = CON_ALU_SUB;
          default: con = CON_IDLE;
        endcase
      end
      HALT: begin
        hlt = 1'b1;
      end
      default: begin
        con = CON_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_sap_controller.sv
// tb/tb_sap_controller.sv - self-checking bench for sap_controller
module tb_sap_controller;

  logic        clk = 1'b1;
  logic        async_reset;
  logic        run;
  logic [3:0]  opcode;
  logic [11:0] con;
  logic [5:0]  t_state;
  logic        hlt;

  int n_total = 0;
  int n_pass  = 0;

  sap_controller dut (
    .clk         (clk),
    .async_reset (async_reset),
    .run         (run),
    .opcode      (opcode),
    .con         (con),
    .t_state     (t_state),
    .hlt         (hlt)
  );

  // Falling edges at 5, 15, 25 ...; rising edges at 10, 20 ...
  always #5 clk = ~clk;

  typedef struct {
    logic        run;
    logic [3:0]  opcode;
    logic [11:0] exp_con;
    logic [5:0]  exp_t;
    logic        exp_hlt;
  } vec_t;

  vec_t vecs[$];

  // Reference model: step 0 = RESET, 1..6 = T1..T6, 7 = HALT.
  int m_step = 0;

  function automatic logic [11:0] model_con(int step, logic [3:0] op);
    logic [11:0] fetch [3];
    logic [11:0] exec  [3];
    fetch = '{12'h5E3, 12'hBE3, 12'h263};
    case (op)
      4'd0:    exec = '{12'h1A3, 12'h2C3, 12'h3E3};
      4'd1:    exec = '{12'h1A3, 12'h2E1, 12'h3C7};
      4'd2:    exec = '{12'h1A3, 12'h2E1, 12'h3CF};
      4'd14:   exec = '{12'h3F2, 12'h3E3, 12'h3E3};
      default: exec = '{12'h3E3, 12'h3E3, 12'h3E3};
    endcase
    if (step >= 1 && step <= 3) return fetch[step-1];
    if (step >= 4 && step <= 6) return exec[step-4];
    return 12'h3E3;
  endfunction

  function automatic logic [5:0] model_t(int step);
    logic [5:0] one = 6'b000001;
    if (step >= 1 && step <= 6) return one << (step - 1);
    return 6'b000000;
  endfunction

  function automatic int model_next(int step, logic r, logic [3:0] op);
    if (!r)        return step;
    if (step == 7) return 7;
    if (step == 4 && op == 4'hF) return 7;
    if (step == 6) return 1;
    return step + 1;
  endfunction

  task automatic chk(string name, logic [11:0] ec, logic [5:0] et, logic eh);
    n_total++;
    if (con === ec && t_state === et && hlt === eh) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got con=%03h t_state=%06b hlt=%0b, expected con=%03h t_state=%06b hlt=%0b",
               name, con, t_state, hlt, ec, et, eh);
    end
  endtask

  // One falling edge, then sample one time unit after the following rising edge.
  task automatic tick();
    @(negedge clk);
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t mk(logic r, logic [3:0] op, logic [11:0] c, logic [5:0] t, logic h);
    vec_t v;
    v.run = r; v.opcode = op; v.exp_con = c; v.exp_t = t; v.exp_hlt = h;
    return v;
  endfunction

  initial begin
    async_reset = 1'b1;
    run         = 1'b0;
    opcode      = 4'h0;

    // LDA, SUB, ADD, OUT, NOP back to back.
    vecs.push_back(mk(1, 4'h0, 12'h5E3, 6'b000001, 0));
    vecs.push_back(mk(1, 4'h0, 12'hBE3, 6'b000010, 0));
    vecs.push_back(mk(1, 4'h0, 12'h263, 6'b000100, 0));
    vecs.push_back(mk(1, 4'h0, 12'h1A3, 6'b001000, 0));
    vecs.push_back(mk(1, 4'h0, 12'h2C3, 6'b010000, 0));
    vecs.push_back(mk(1, 4'h0, 12'h3E3, 6'b100000, 0));
    vecs.push_back(mk(1, 4'h2, 12'h5E3, 6'b000001, 0));
    vecs.push_back(mk(1, 4'h2, 12'hBE3, 6'b000010, 0));
    vecs.push_back(mk(1, 4'h2, 12'h263, 6'b000100, 0));
    vecs.push_back(mk(1, 4'h2, 12'h1A3, 6'b001000, 0));
    vecs.push_back(mk(1, 4'h2, 12'h2E1, 6'b010000, 0));
    vecs.push_back(mk(1, 4'h2, 12'h3CF, 6'b100000, 0));
    vecs.push_back(mk(1, 4'h1, 12'h5E3, 6'b000001, 0));
    vecs.push_back(mk(1, 4'h1, 12'hBE3, 6'b000010, 0));
    vecs.push_back(mk(1, 4'h1, 12'h263, 6'b000100, 0));
    vecs.push_back(mk(1, 4'h1, 12'h1A3, 6'b001000, 0));
    vecs.push_back(mk(1, 4'h1, 12'h2E1, 6'b010000, 0));
    vecs.push_back(mk(1, 4'h1, 12'h3C7, 6'b100000, 0));
    vecs.push_back(mk(1, 4'hE, 12'h5E3, 6'b000001, 0));
    vecs.push_back(mk(1, 4'hE, 12'hBE3, 6'b000010, 0));
    vecs.push_back(mk(1, 4'hE, 12'h263, 6'b000100, 0));
    vecs.push_back(mk(1, 4'hE, 12'h3F2, 6'b001000, 0));
    vecs.push_back(mk(1, 4'hE, 12'h3E3, 6'b010000, 0));
    vecs.push_back(mk(1, 4'hE, 12'h3E3, 6'b100000, 0));
    vecs.push_back(mk(1, 4'h5, 12'h5E3, 6'b000001, 0));
    vecs.push_back(mk(1, 4'h5, 12'hBE3, 6'b000010, 0));
    vecs.push_back(mk(1, 4'h5, 12'h263, 6'b000100, 0));
    vecs.push_back(mk(1, 4'h5, 12'h3E3, 6'b001000, 0));
    vecs.push_back(mk(1, 4'h5, 12'h3E3, 6'b010000, 0));
    vecs.push_back(mk(1, 4'h5, 12'h3E3, 6'b100000, 0));

    // Reset state, sampled mid high phase.
    #12;
    chk("reset_state", 12'h3E3, 6'b000000, 1'b0);
    run = 1'b1;
    #1;
    async_reset = 1'b0;

    foreach (vecs[i]) begin
      run    = vecs[i].run;
      opcode = vecs[i].opcode;
      tick();
      chk($sformatf("vec%0d", i), vecs[i].exp_con, vecs[i].exp_t, vecs[i].exp_hlt);
    end

    // Pause during T3 of an LDA, then resume into T4.
    opcode = 4'h0;
    tick(); tick(); tick();
    chk("pause_t3_entry", 12'h263, 6'b000100, 1'b0);
    run = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk($sformatf("pause_hold%0d", i), 12'h263, 6'b000100, 1'b0);
    end
    run = 1'b1;
    tick();
    chk("pause_resume_t4", 12'h1A3, 6'b001000, 1'b0);
    tick(); tick();

    // ADD interrupted at T5 by a reset pulse between edges.
    opcode = 4'h1;
    for (int i = 0; i < 5; i++) tick();
    chk("add_t5", 12'h2E1, 6'b010000, 1'b0);
    async_reset = 1'b1;
    #1;
    chk("reset_mid_t5", 12'h3E3, 6'b000000, 1'b0);
    #1;
    async_reset = 1'b0;
    #1;
    chk("reset_released", 12'h3E3, 6'b000000, 1'b0);
    tick();
    chk("after_reset_t1", 12'h5E3, 6'b000001, 1'b0);

    // HLT: T4 idle, HALT on the next falling edge, held regardless of inputs.
    opcode = 4'hF;
    tick(); tick(); tick();
    chk("hlt_t4", 12'h3E3, 6'b001000, 1'b0);
    tick();
    chk("hlt_enter", 12'h3E3, 6'b000000, 1'b1);
    for (int i = 0; i < 20; i++) begin
      run    = 1'($urandom_range(0, 1));
      opcode = 4'($urandom_range(0, 15));
      tick();
      chk($sformatf("hlt_hold%0d", i), 12'h3E3, 6'b000000, 1'b1);
    end
    async_reset = 1'b1;
    #1;
    chk("reset_from_halt", 12'h3E3, 6'b000000, 1'b0);
    #1;
    async_reset = 1'b0;
    m_step = 0;

    // Randomized run/opcode/reset against the model.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 29) == 0) begin
        async_reset = 1'b1;
        #1;
        m_step = 0;
        chk($sformatf("rnd_reset%0d", i), model_con(m_step, opcode), model_t(m_step), 1'b0);
        #1;
        async_reset = 1'b0;
      end
      run = ($urandom_range(0, 3) != 0);
      // Opcode stays stable through T4-T6; it may wander anywhere else.
      if (m_step < 3 || m_step == 7) opcode = 4'($urandom_range(0, 15));
      m_step = model_next(m_step, run, opcode);
      tick();
      chk($sformatf("rnd%0d", i), model_con(m_step, opcode), model_t(m_step), m_step == 7);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
